jtgng_rom_slots: RTL

- Three-client ROM request arbiter with a one-entry cache per client.
- Sits directly upstream of the SDRAM controller and drives its sdram_addr, read_sync (toggle strobe) and read_req (refresh inhibit). Captures the controller's 32-bit data_read after a fixed latency.
- Serves CPU/graphics ROM clients with 16-bit words.
- Cache hits never touch SDRAM, which frees controller slots for refresh.

---
 rtl/jtgng_rom_slots_pkg.sv | 14 +
 rtl/jtgng_rom_slots_if.sv | 17 +
 rtl/jtgng_rom_slot_cache.sv | 54 +++++
 rtl/jtgng_rom_slots.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jtgng_rom_slots_pkg.sv
// Shared definitions for the three-slot ROM arbiter.
//   state_t     : arbiter FSM states
//   SLOTS       : number of ROM clients
//   SDRAM_AW    : SDRAM word-address width
//   LATENCY_DEF : default read_sync-to-data_read latency in clk cycles
package jtgng_rom_slots_pkg;

   localparam int SLOTS       = 3;
   localparam int SDRAM_AW    = 22;
   localparam int LATENCY_DEF = 12;

   typedef enum logic {IDLE, WAIT} state_t;

endpackage

// File: rtl/jtgng_rom_slots_if.sv
// SDRAM controller read port as seen by the ROM arbiter.
//   sdram_addr : word address, bit 0 always 0 (32-bit pair fetch)
//   read_sync  : toggles once per read request
//   read_req   : high while a read is outstanding (inhibits refresh)
//   data_read  : {word addr+1, word addr} after the controller latency
// master = arbiter side, slave = controller side.
interface jtgng_rom_slots_if;
   import jtgng_rom_slots_pkg::*;

   logic [SDRAM_AW-1:0] sdram_addr;
   logic                read_sync;
   logic                read_req;
   logic [31:0]         data_read;

   modport master (output sdram_addr, read_sync, read_req, input data_read);
   modport slave  (input sdram_addr, read_sync, read_req, output data_read);
endinterface

// File: rtl/jtgng_rom_slot_cache.sv
// One-entry 32-bit cache for a single ROM client.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : invalidate entry and force ok low on the next edge
//   cs, addr   : client request and word address
//   we, wtag,
//   wdata      : fill from the arbiter (tag = addr[AW-1:1])
//   hit        : combinational hit for the current addr
//   ok, dout   : registered valid flag and selected 16-bit word
module jtgng_rom_slot_cache
   import jtgng_rom_slots_pkg::*;
#(
   parameter int AW = 15
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [AW-2:0] wtag,
   input  logic [31:0]   wdata,
   output logic          hit,
   output logic          ok,
   output logic [15:0]   dout
);

   logic [AW-2:0] tag;
   logic [31:0]   data;
   logic          valid;

   assign hit = valid && (tag == addr[AW-1:1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag   <= '0;
         data  <= '0;
         valid <= 1'b0;
         ok    <= 1'b0;
         dout  <= '0;
      end else begin
         if (clr) begin
            valid <= 1'b0;
         end else if (we) begin
            valid <= 1'b1;
            tag   <= wtag;
            data  <= wdata;
         end
         // valid is still set on the first clr cycle, so gate ok explicitly
         ok   <= cs && hit && !clr;
         dout <= addr[0] ? data[31:16] : data[15:0];
      end
   end

endmodule

// File: rtl/jtgng_rom_slots.sv
// Three-client ROM arbiter with a one-entry cache per client, placed in
// front of the SDRAM controller. Misses are fetched as 32-bit pairs with
// fixed priority slot0 > slot1 > slot2; hits never reach SDRAM.
//   clk, rst_n            : clock, synchronous active-low reset
//   downloading           : ROM load; invalidates caches, blocks requests
//   loop_rst              : controller init; blocks/aborts requests
//   slotK_cs/addr         : client request and word address
//   slotK_ok/dout         : registered data valid and 16-bit word
//   sdram (master)        : sdram_addr, read_sync, read_req, data_read
module jtgng_rom_slots
   import jtgng_rom_slots_pkg::*;
#(
   parameter int                  AW0     = 17,
   parameter int                  AW1     = 15,
   parameter int                  AW2     = 15,
   parameter logic [SDRAM_AW-1:0] OFF0    = 22'h0,
   parameter logic [SDRAM_AW-1:0] OFF1    = 22'h20000,
   parameter logic [SDRAM_AW-1:0] OFF2    = 22'h28000,
   parameter int                  LATENCY = LATENCY_DEF
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           downloading,
   input  logic           loop_rst,
   input  logic           slot0_cs,
   input  logic [AW0-1:0] slot0_addr,
   output logic           slot0_ok,
   output logic [15:0]    slot0_dout,
   input  logic           slot1_cs,
   input  logic [AW1-1:0] slot1_addr,
   output logic           slot1_ok,
   output logic [15:0]    slot1_dout,
   input  logic           slot2_cs,
   input  logic [AW2-1:0] slot2_addr,
   output logic           slot2_ok,
   output logic [15:0]    slot2_dout,
   jtgng_rom_slots_if.master sdram
);

   localparam int MAXAW = (AW0 > AW1) ? ((AW0 > AW2) ? AW0 : AW2)
                                      : ((AW1 > AW2) ? AW1 : AW2);
   localparam int CW    = $clog2(LATENCY + 1);

   logic [SLOTS-1:0]                cs_v, hit_v, pend, we_v, ok_v;
   logic [SLOTS-1:0][MAXAW-1:0]     addr_v;
   logic [SLOTS-1:0][SDRAM_AW-1:0]  base_v;
   logic [SLOTS-1:0][15:0]          dout_v;

   state_t           st, st_nxt;
   logic [CW-1:0]    cnt;
   logic [1:0]       gidx, gnt_idx;
   logic [MAXAW-2:0] gtag;
   logic             gnt_any, issue, fill, drop;

   assign cs_v      = {slot2_cs, slot1_cs, slot0_cs};
   assign addr_v[0] = MAXAW'(slot0_addr);
   assign addr_v[1] = MAXAW'(slot1_addr);
   assign addr_v[2] = MAXAW'(slot2_addr);
   assign pend      = cs_v & ~hit_v & {SLOTS{~downloading}};

   assign {slot2_ok,   slot1_ok,   slot0_ok}   = ok_v;
   assign {slot2_dout, slot1_dout, slot0_dout} = dout_v;

   for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      localparam int                  AWK  = (k == 0) ? AW0 : (k == 1) ? AW1 : AW2;
      localparam logic [SDRAM_AW-1:0] OFFK = (k == 0) ? OFF0 : (k == 1) ? OFF1 : OFF2;
      logic [SDRAM_AW-1:0] sum;

      // pair address: even word inside the slot's SDRAM window
      assign sum       = OFFK + SDRAM_AW'({addr_v[k][AWK-1:1], 1'b0});
      assign base_v[k] = {sum[SDRAM_AW-1:1], 1'b0};

      jtgng_rom_slot_cache #(.AW(AWK)) u_cache (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (downloading),
         .cs    (cs_v[k]),
         .addr  (addr_v[k][AWK-1:0]),
         .we    (we_v[k]),
         .wtag  (gtag[AWK-2:0]),
         .wdata (sdram.data_read),
         .hit   (hit_v[k]),
         .ok    (ok_v[k]),
         .dout  (dout_v[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt  = st;
      issue   = 1'b0;
      fill    = 1'b0;
      drop    = 1'b0;
      gnt_any = 1'b0;
      gnt_idx = 2'd0;
      we_v    = '0;
      // descending scan so the lowest pending index wins
      for (int k = SLOTS-1; k >= 0; k--) begin
         if (pend[k]) begin
            gnt_any = 1'b1;
            gnt_idx = 2'(k);
         end
      end
      case (st)
         IDLE: begin
            if (loop_rst || downloading) drop = 1'b1;
            else if (gnt_any) begin
               issue  = 1'b1;
               st_nxt = WAIT;
            end else drop = 1'b1;
         end
         WAIT: begin
            if (loop_rst || downloading) begin
               drop   = 1'b1;
               st_nxt = IDLE;
            end else if (cnt == '0) begin
               fill   = 1'b1;
               st_nxt = IDLE;
            end
         end
         default: st_nxt = IDLE;
      endcase
      if (fill) we_v[gidx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt              <= '0;
         gidx             <= '0;
         gtag             <= '0;
         sdram.sdram_addr <= '0;
         sdram.read_sync  <= 1'b0;
         sdram.read_req   <= 1'b0;
      end else begin
         if (issue) begin
            sdram.sdram_addr <= base_v[gnt_idx];
            sdram.read_sync  <= ~sdram.read_sync;
            sdram.read_req   <= 1'b1;
            cnt              <= CW'(LATENCY - 1);
            gidx             <= gnt_idx;
            gtag             <= addr_v[gnt_idx][MAXAW-1:1];
         end else if (drop) begin
            sdram.read_req   <= 1'b0;
         end
         if (st == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      end
   end

endmodule
